uart_rx_param: RTL and testbench

Parametrised oversampling UART receiver, successor to the fixed 8N1 receiver in the UART loopback path. It is driven by the shared baud-rate tick generator at OVERSAMPLE× the bit rate. Data width, stop-bit length and optional parity (even/odd) are configurable. It adds input synchronisation, false-start rejection, parity/framing error flags and break handling, none of which the current receiver has.

---
 rtl/uart_rx_param.sv | 179 +++++++++++++++++
 tb/tb_uart_rx_param.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable data width, stop length and parity.
// Adds an input synchroniser, false-start rejection, parity/framing flags and break handling.
module uart_rx_param #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned SB_TICKS   = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_tick,
  input  logic                 i_rx_data_input,
  output logic [DATA_BITS-1:0] o_data_byte,
  output logic                 o_done_bit,
  output logic                 o_parity_error,
  output logic                 o_frame_error,
  output logic                 o_busy
);

  localparam int unsigned SMax = (OVERSAMPLE > SB_TICKS) ? OVERSAMPLE : SB_TICKS;
  localparam int unsigned SW   = $clog2(SMax);
  localparam int unsigned NW   = $clog2(DATA_BITS);

  localparam logic [SW-1:0] SHalf = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SFull = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SStop = SW'(SB_TICKS - 1);
  localparam logic [SW-1:0] SOne  = SW'(1);
  localparam logic [NW-1:0] NLast = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] NOne  = NW'(1);
  localparam logic          ParEn  = (PARITY_EN != 0);
  localparam logic          ParOdd = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q;
  logic [SW-1:0]        s_q, s_d;
  logic [NW-1:0]        n_q, n_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;
  logic                 rx;

  assign rx = sync2_q;

  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    sr_d         = sr_q;
    perr_d       = perr_q;
    data_d       = data_q;
    done_d       = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    unique case (state_q)
      StIdle: begin
        if (!rx) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: begin
        if (i_tick) begin
          if (s_q == SHalf) begin
            // A high line at mid-start is a glitch: drop back without reporting.
            if (!rx) begin
              state_d = StData;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + SOne;
          end
        end
      end
      StData: begin
        if (i_tick) begin
          if (s_q == SFull) begin
            s_d  = '0;
            sr_d = {rx, sr_q[DATA_BITS-1:1]};
            if (n_q == NLast) begin
              state_d = ParEn ? StParity : StStop;
            end else begin
              n_d = n_q + NOne;
            end
          end else begin
            s_d = s_q + SOne;
          end
        end
      end
      StParity: begin
        if (i_tick) begin
          if (s_q == SFull) begin
            s_d     = '0;
            perr_d  = (^sr_q) ^ rx ^ ParOdd;
            state_d = StStop;
          end else begin
            s_d = s_q + SOne;
          end
        end
      end
      StStop: begin
        if (i_tick) begin
          if (s_q == SStop) begin
            s_d          = '0;
            data_d       = sr_q;
            parity_err_d = ParEn & perr_q;
            frame_err_d  = ~rx;
            done_d       = 1'b1;
            state_d      = rx ? StIdle : StBreak;
          end else begin
            s_d = s_q + SOne;
          end
        end
      end
      StBreak: begin
        if (rx) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= StIdle;
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      s_q          <= '0;
      n_q          <= '0;
      sr_q         <= '0;
      perr_q       <= 1'b0;
      data_q       <= '0;
      done_q       <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= i_rx_data_input;
      sync2_q      <= sync1_q;
      s_q          <= s_d;
      n_q          <= n_d;
      sr_q         <= sr_d;
      perr_q       <= perr_d;
      data_q       <= data_d;
      done_q       <= done_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
    end
  end

  assign o_data_byte    = data_q;
  assign o_done_bit     = done_q;
  assign o_parity_error = parity_err_q;
  assign o_frame_error  = frame_err_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: default 8N1, 8E1 and 7-bit/2-stop instances
// share clock, reset and a tick every 4 clocks (64 clocks per bit).
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic tick;
  logic rx0, rx1, rx2;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic done0, done1, done2, pe0, pe1, pe2, fe0, fe1, fe2, busy0, busy1, busy2;

  int checks = 0;
  int errors = 0;

  uart_rx_param u_dut0 (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx_data_input(rx0),
    .o_data_byte(d0), .o_done_bit(done0), .o_parity_error(pe0),
    .o_frame_error(fe0), .o_busy(busy0)
  );

  uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx_data_input(rx1),
    .o_data_byte(d1), .o_done_bit(done1), .o_parity_error(pe1),
    .o_frame_error(fe1), .o_busy(busy1)
  );

  uart_rx_param #(.DATA_BITS(7), .SB_TICKS(32)) u_dut2 (
    .i_clock(clk), .i_reset(rst), .i_tick(tick), .i_rx_data_input(rx2),
    .o_data_byte(d2), .o_done_bit(done2), .o_parity_error(pe2),
    .o_frame_error(fe2), .o_busy(busy2)
  );

  initial begin
    int cnt;
    cnt  = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      cnt  = (cnt + 1) % 4;
      tick = (cnt == 3);
    end
  end

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    logic       busy;
  } rec_t;

  // One record per done pulse, captured the cycle after it (busy shows the post-frame state).
  rec_t q0[$], q1[$], q2[$];
  logic done0_d1 = 1'b0, done1_d1 = 1'b0, done2_d1 = 1'b0;

  always @(negedge clk) begin
    done0_d1 <= done0;
    done1_d1 <= done1;
    done2_d1 <= done2;
    if (done0_d1) q0.push_back('{{1'b0, d0}, pe0, fe0, busy0});
    if (done1_d1) q1.push_back('{{1'b0, d1}, pe1, fe1, busy1});
    if (done2_d1) q2.push_back('{{2'b0, d2}, pe2, fe2, busy2});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int sel);
    case (sel)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic set_rx(input int sel, input logic v);
    case (sel)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // Drives one frame; cut>0 abandons it (line high) after that many clocks.
  task automatic send(input int sel, input logic [8:0] data, input int nbits, input bit par_en,
                      input bit par_bit, input bit stop_lvl, input int stop_clks, input int cut);
    logic [11:0] fb;
    int len;
    int t;
    fb  = '0;
    len = 1 + nbits;
    t   = 0;
    for (int i = 0; i < nbits; i++) fb[1+i] = data[i];
    if (par_en) begin
      fb[len] = par_bit;
      len++;
    end
    for (int b = 0; b < len; b++) begin
      set_rx(sel, fb[b]);
      for (int c = 0; c < 64; c++) begin
        if (cut > 0 && t == cut) begin
          set_rx(sel, 1'b1);
          return;
        end
        @(negedge clk);
        t++;
      end
    end
    set_rx(sel, stop_lvl);
    repeat (stop_clks) @(negedge clk);
    set_rx(sel, 1'b1);
  endtask

  task automatic get_rec(input int sel, output rec_t r, output bit ok);
    ok = 1'b0;
    r  = '{9'h0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 400; i++) begin
      if (qsize(sel) > 0) begin
        case (sel)
          0:       r = q0.pop_front();
          1:       r = q1.pop_front();
          default: r = q2.pop_front();
        endcase
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string name, input int sel, input logic [8:0] exp_data,
                             input bit exp_perr, input bit exp_ferr, input bit exp_busy);
    rec_t r;
    bit ok;
    get_rec(sel, r, ok);
    chk({name, "_done"}, 32'(ok), 32'd1);
    if (ok) begin
      chk({name, "_data"}, 32'(r.data), 32'(exp_data));
      chk({name, "_perr"}, 32'(r.perr), 32'(exp_perr));
      chk({name, "_ferr"}, 32'(r.ferr), 32'(exp_ferr));
      chk({name, "_busy"}, 32'(r.busy), 32'(exp_busy));
    end
    chk({name, "_single"}, 32'(qsize(sel)), 32'd0);
  endtask

  typedef struct {
    string      name;
    int         sel;
    logic [8:0] data;
    int         nbits;
    bit         par_en;
    bit         par_bit;
    int         idle;
    int         stop_clks;
    logic [8:0] exp_data;
    bit         exp_perr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{"aa_8n1",     0, 9'h0AA, 8, 1'b0, 1'b0, 64, 64,  9'h0AA, 1'b0};
    vecs[1] = '{"par_ok",     1, 9'h05B, 8, 1'b1, 1'b1, 64, 64,  9'h05B, 1'b0};
    vecs[2] = '{"par_bad",    1, 9'h05B, 8, 1'b1, 1'b0, 64, 64,  9'h05B, 1'b1};
    vecs[3] = '{"d7_2stop",   2, 9'h055, 7, 1'b0, 1'b0, 64, 128, 9'h055, 1'b0};
    vecs[4] = '{"b2b_first",  0, 9'h001, 8, 1'b0, 1'b0, 64, 64,  9'h001, 1'b0};
    vecs[5] = '{"b2b_second", 0, 9'h0FE, 8, 1'b0, 1'b0, 0,  64,  9'h0FE, 1'b0};

    rst = 1'b1;
    rx0 = 1'b1;
    rx1 = 1'b1;
    rx2 = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_data", 32'(d0), 32'h0);
    chk("rst_done", 32'(done0), 32'h0);
    chk("rst_perr", 32'(pe0), 32'h0);
    chk("rst_ferr", 32'(fe0), 32'h0);
    chk("rst_busy0", 32'(busy0), 32'h0);
    chk("rst_busy1", 32'(busy1), 32'h0);
    chk("rst_busy2", 32'(busy2), 32'h0);
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      repeat (vecs[v].idle) @(negedge clk);
      send(vecs[v].sel, vecs[v].data, vecs[v].nbits, vecs[v].par_en, vecs[v].par_bit, 1'b1,
           vecs[v].stop_clks, 0);
      check_frame(vecs[v].name, vecs[v].sel, vecs[v].exp_data, vecs[v].exp_perr, 1'b0, 1'b0);
    end

    // Stop bit low, line held low for three bit times, then released.
    repeat (64) @(negedge clk);
    send(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 192, 0);
    check_frame("break", 0, 9'h03C, 1'b0, 1'b1, 1'b1);
    chk("break_hold", 32'(busy0), 32'h1);
    repeat (6) @(negedge clk);
    chk("break_exit", 32'(busy0), 32'h0);
    repeat (64) @(negedge clk);
    send(0, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 64, 0);
    check_frame("after_break", 0, 9'h03C, 1'b0, 1'b0, 1'b0);

    // 3-tick low glitch on an idle line.
    repeat (64) @(negedge clk);
    rx0 = 1'b0;
    repeat (8) @(negedge clk);
    chk("glitch_start", 32'(busy0), 32'h1);
    repeat (4) @(negedge clk);
    rx0 = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_idle", 32'(busy0), 32'h0);
    chk("glitch_nodone", 32'(qsize(0)), 32'd0);
    repeat (64) @(negedge clk);
    send(0, 9'h081, 8, 1'b0, 1'b0, 1'b1, 64, 0);
    check_frame("after_glitch", 0, 9'h081, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of data bit 4 of 0xC3.
    repeat (64) @(negedge clk);
    send(0, 9'h0C3, 8, 1'b0, 1'b0, 1'b1, 64, 352);
    chk("midrst_busy_before", 32'(busy0), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_data", 32'(d0), 32'h0);
    chk("midrst_done", 32'(done0), 32'h0);
    chk("midrst_perr", 32'(pe0), 32'h0);
    chk("midrst_ferr", 32'(fe0), 32'h0);
    chk("midrst_busy", 32'(busy0), 32'h0);
    repeat (100) @(negedge clk);
    chk("midrst_nodone", 32'(qsize(0)), 32'd0);
    send(0, 9'h077, 8, 1'b0, 1'b0, 1'b1, 64, 0);
    check_frame("after_rst", 0, 9'h077, 1'b0, 1'b0, 1'b0);

    repeat (200) @(negedge clk);
    chk("final_q0", 32'(qsize(0)), 32'd0);
    chk("final_q1", 32'(qsize(1)), 32'd0);
    chk("final_q2", 32'(qsize(2)), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
